// File: rtl/pal_pkg.sv
// Shared definitions for the PAL fabric and its configuration loader:
// default fabric dimensions, configuration length and loader states.
package pal_pkg;

  localparam int PAL_N = 8;
  localparam int PAL_M = 4;
  localparam int PAL_P = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BYTE = 2'd1,
    SHIFT     = 2'd2
  } loader_state_e;

  // AND plane (true and complement of every input per term) plus OR plane.
  function automatic int cfg_bits(input int n, input int p, input int m);
    return 2 * n * p + p * m;
  endfunction

endpackage

// File: rtl/pal_cfg_loader.sv
// Byte-wide configuration loader: accepts bytes on a valid/ready handshake and
// serialises them MSB-first into the PAL, raising APPLY once the length is met.
module pal_cfg_loader
  import pal_pkg::*;
#(
  parameter int N = PAL_N,
  parameter int M = PAL_M,
  parameter int P = PAL_P
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       START,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic       CFG_BIT,
  output logic       CFG_EN,
  output logic       APPLY,
  output logic       BUSY
);

  localparam int CFG_BITS = cfg_bits(N, P, M);
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS);

  loader_state_e    state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s, remain_s;
  logic [3:0]       left_r, left_s;
  logic [7:0]       shreg_r, shreg_s;
  logic             apply_r, apply_s;
  logic             din_ready_r, cfg_en_r, cfg_bit_r, busy_r;

  // Next-state, counter and shifter logic; START overrides everything else.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    left_s   = left_r;
    shreg_s  = shreg_r;
    apply_s  = apply_r;
    remain_s = CNT_LAST - count_r;
    if (START) begin
      state_s = WAIT_BYTE;
      count_s = {CNT_W{1'b0}};
      left_s  = 4'd0;
      shreg_s = 8'd0;
      apply_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        WAIT_BYTE: begin
          if (DIN_VALID) begin
            shreg_s = DIN;
            // The final byte only contributes the bits still missing.
            left_s  = (remain_s >= CNT_W'(4'd8)) ? 4'd8 : remain_s[3:0];
            state_s = SHIFT;
          end else begin
            state_s = WAIT_BYTE;
          end
        end
        SHIFT: begin
          shreg_s = {shreg_r[6:0], 1'b0};
          count_s = count_r + CNT_W'(1'b1);
          left_s  = left_r - 4'd1;
          if (left_r == 4'd1) begin
            if (count_s == CNT_LAST) begin
              state_s = IDLE;
              apply_s = 1'b1;
            end else begin
              state_s = WAIT_BYTE;
            end
          end else begin
            state_s = SHIFT;
          end
        end
        default: begin
          state_s = IDLE;
          apply_s = 1'b0;
        end
      endcase
    end
  end

  // State, counter and shift register storage.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_r <= IDLE;
      count_r <= {CNT_W{1'b0}};
      left_r  <= 4'd0;
      shreg_r <= 8'd0;
      apply_r <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      left_r  <= left_s;
      shreg_r <= shreg_s;
      apply_r <= apply_s;
    end
  end

  // Outputs registered from next-state values so they line up with the state.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      din_ready_r <= 1'b0;
      cfg_en_r    <= 1'b0;
      cfg_bit_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      din_ready_r <= (state_s == WAIT_BYTE);
      cfg_en_r    <= (state_s == SHIFT);
      cfg_bit_r   <= (state_s == SHIFT) & shreg_s[7];
      busy_r      <= (state_s != IDLE);
    end
  end

  assign DIN_READY = din_ready_r;
  assign CFG_EN    = cfg_en_r;
  assign CFG_BIT   = cfg_bit_r;
  assign APPLY     = apply_r;
  assign BUSY      = busy_r;

endmodule

// File: doc/pal_cfg_loader.md
# pal_cfg_loader

Byte-wide configuration loader that sits directly upstream of the PAL fabric. It accepts configuration bytes over a valid/ready handshake and serialises them MSB-first into the PAL's one-bit configuration input, one bit per clock. It counts exactly the PAL's configuration length, then raises the apply/enable level that commits the loaded configuration to the fabric.

## Interface
Parameters:
- N, 8, number of PAL inputs
- M, 4, number of PAL outputs
- P, 15, number of intermediate (product-term) stages
- CFG_BITS, 2*N*P + P*M (300), total configuration bits; derived, not overridden

Ports:
- CLK  in  1  clock; the only clock
- RES  in  1  reset; asynchronous, active-high
- START  in  1  single-cycle pulse; begins a new load and aborts any load in progress
- DIN  in  8  configuration byte
- DIN_VALID  in  1  DIN is valid
- DIN_READY  out  1  loader accepts DIN this cycle
- CFG_BIT  out  1  serial configuration bit to the PAL CFG input
- CFG_EN  out  1  CFG_BIT is valid this cycle; the PAL shifts on it
- APPLY  out  1  level; configuration is complete and applied; drives the PAL EN
- BUSY  out  1  a load is in progress

## Operation
- Reset values: all outputs 0, state IDLE, bit counter 0, shift register 0.
- IDLE:
  - DIN_READY=0, BUSY=0.
  - APPLY holds its last value.
  - START moves to WAIT_BYTE, clears the bit counter and clears APPLY.
- WAIT_BYTE:
  - DIN_READY=1, BUSY=1.
  - On DIN_VALID & DIN_READY: latch DIN into the 8-bit shift register.
  - Set byte_left = min(8, CFG_BITS − count).
  - Move to SHIFT.
- SHIFT:
  - DIN_READY=0, CFG_EN=1, CFG_BIT=shreg[7].
  - Each cycle: shift left, count+1, byte_left−1.
  - When byte_left reaches 0: if count == CFG_BITS, go to IDLE and set APPLY; otherwise go to WAIT_BYTE.
- Final byte:
  - Only its top (CFG_BITS mod 8) bits are shifted; the rest are discarded.
  - Default: 38 bytes, the last contributing bits 7..4.
- START in WAIT_BYTE or SHIFT:
  - Abort and restart in WAIT_BYTE with count=0 and APPLY=0.
  - A byte offered in the same cycle as START is not accepted.
- START has priority over the handshake and the shift in the same cycle.
- DIN_VALID in IDLE or SHIFT is ignored; no byte is consumed.
- Counter width: $clog2(CFG_BITS+1). It never exceeds CFG_BITS.
- RES asserted at any time, including mid-shift: immediate return to reset values. APPLY=0, so a partially shifted PAL configuration is never applied.

## Timing
- Byte accepted at the rising edge where DIN_VALID & DIN_READY. The first CFG_EN of that byte is high in the next cycle.
- Full byte: 8 consecutive CFG_EN cycles followed by ≥1 WAIT_BYTE cycle. Minimum 9 cycles per byte.
- APPLY and BUSY are registered. APPLY rises, and BUSY falls, in the cycle after the last CFG_EN.
- APPLY falls in the cycle after START is sampled.
- Minimum total load time (default, VALID always high): 1 START cycle + 37×9 + 1 + 4 = 339 cycles from START to APPLY.
- CFG_BIT is 0 whenever CFG_EN=0.

## Structure
- Shared package pal_pkg:
  - default N, M, P
  - function cfg_bits(N,P,M)
  - loader state enum {IDLE, WAIT_BYTE, SHIFT}
- Single module. No sub-module; the counter and shifter are too small to split.

## Test plan
- Reset mid-load: assert RES after 100 CFG_EN pulses → next cycle all outputs 0. After RES release, no CFG_EN until START.
- Full load, VALID always high, bytes 0x00..0x24 then 0xA5 → exactly 300 CFG_EN pulses. Bit stream MSB-first matches the bytes. The last four bits are 1,0,1,0. APPLY=1 one cycle after the final CFG_EN. BUSY=0. Total 339 cycles from START.
- Backpressure: random 0–5 cycle VALID gaps → identical 300-bit stream. CFG_EN never high in WAIT_BYTE. APPLY is set only once.
- Abort: START after 100 bits → count restarts. APPLY stays 0. 300 further bits are required before APPLY rises.
- Re-load: START while APPLY=1 → APPLY=0 the next cycle, DIN_READY=1.
- Idle ignore: DIN_VALID=1 in IDLE for 10 cycles → DIN_READY=0, no CFG_EN, APPLY unchanged.
